ddr_axi_slave_mem: RTL and testbench
====================================

Name: ddr_axi_slave_mem

Overview:
- AXI4 memory-mapped slave responder that terminates the DDR_interface M00_AXI master port.
- Replaces the VIP slave memory in system-level simulation and serves as an on-chip scratch memory in hardware bring-up.
- Holds a register-array memory and services one burst at a time, read or write, with full-width beats only.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 1, AXI ID width.
- MEM_DEPTH, 1024, memory words; must be a power of two.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset; asynchronous assert, active-low
- S_AXI_AWID  in  ID_WIDTH  write address ID
- S_AXI_AWADDR  in  ADDR_WIDTH  write start byte address
- S_AXI_AWLEN  in  8  write beats minus one
- S_AXI_AWBURST  in  2  write burst type
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address accepted
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- S_AXI_WLAST  in  1  last write beat
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data accepted
- S_AXI_BID  out  ID_WIDTH  echoes AWID
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  response valid
- S_AXI_BREADY  in  1  response accepted
- S_AXI_ARID  in  ID_WIDTH  read address ID
- S_AXI_ARADDR  in  ADDR_WIDTH  read start byte address
- S_AXI_ARLEN  in  8  read beats minus one
- S_AXI_ARBURST  in  2  read burst type
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address accepted
- S_AXI_RID  out  ID_WIDTH  echoes ARID
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RLAST  out  1  last read beat
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data accepted

Behaviour:
- Reset: every output is 0; the FSM enters IDLE; the arbitration pointer selects write. Memory contents are not reset.
- Word index: addr[ADDR_LSB +: log2(MEM_DEPTH)], where ADDR_LSB = log2(DATA_WIDTH/8). Any address at or above MEM_DEPTH*DATA_WIDTH/8 is out of range.
- FSM states:
  - IDLE: AWREADY and ARREADY are driven combinationally from the grant. When AWVALID and ARVALID are both high, the pointer decides the grant and then toggles. When only one is high, it is granted. The handshake latches ID, address, LEN and BURST, clears the beat counter, and moves to WDATA or RDATA.
  - WDATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB. After the beat, the address advances by DATA_WIDTH/8 for INCR and holds for FIXED. The beat counter is the authority: after LEN+1 beats, move to WRESP.
  - WRESP: BVALID=1, held until BREADY; then return to IDLE.
  - RDATA: RDATA is read asynchronously from the array. RVALID=1 and RLAST = (count==LEN). RDATA, RRESP and RLAST stay stable while RVALID && !RREADY. Return to IDLE after the handshake on the final beat.
- Responses:
  - WRAP burst (2'b10) or reserved (2'b11): treated as INCR for addressing; write response SLVERR, each read beat SLVERR.
  - Out-of-range beat: writes are dropped and BRESP is DECERR, which takes precedence over SLVERR. Reads return RDATA=0 and RRESP=DECERR for that beat only. An INCR burst that crosses the top of memory errors only the beats beyond the top.
  - WLAST low on the final counted beat, or high on an earlier beat: BRESP SLVERR. Data is still written.
- No outstanding-transaction overlap: AWREADY=ARREADY=0 outside IDLE.
- ARESETN asserted mid-burst: immediate return to reset values. No B or R response is issued for the aborted burst. Bytes already written keep their new values.
- Minimum latency: AW handshake to first WREADY is 1 cycle; last W beat to BVALID is 1 cycle; AR handshake to RVALID is 1 cycle.

Optional Feature:
- Macro: DDR_SLV_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle. When its bit 0 is 1, WREADY is gated off in WDATA and RVALID is gated off in RDATA. A new R beat may be delayed, but once RVALID rises it stays high until RREADY.
- Undefined: no gating; WREADY and RVALID are continuous in their states.

Decomposition:
- Package ddr_axi_pkg holds:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - BURST_FIXED/INCR/WRAP constants;
  - the state_t enum {IDLE, WDATA, WRESP, RDATA};
  - the LFSR seed and taps.
- Sub-module ddr_axi_stall_lfsr (ACLK, ARESETN, stall out) is instantiated only under DDR_SLV_STALL_EN.

Test Plan:
- INCR write, AWADDR=0x10, AWLEN=3, data 0x11..0x44, WSTRB=4'hF; then INCR read of the same range -> BRESP=OKAY; RDATA 0x11,0x22,0x33,0x44; RLAST only on beat 4.
- Single write 0xDEADBEEF with WSTRB=4'b0101 over a word holding 0x00000000; read it back -> 0x00AD00EF.
- AWVALID and ARVALID rise in the same cycle twice in a row -> first grant is write, second is read. BID and RID echo AWID=1 and ARID=0.
- Read of AWLEN=1 burst at byte address 0xFFC with MEM_DEPTH=1024 -> beat 1 OKAY, beat 2 DECERR with RDATA=0.
- Write with AWLEN=2 where WLAST is asserted on beat 2 -> three beats accepted, BRESP=SLVERR. FIXED burst of 4 beats -> only the last value is present at the address.
- ARESETN pulled low during beat 2 of an 8-beat read -> all outputs 0 within the same cycle; a new read after release completes with OKAY.

Source files
------------

// File: rtl/ddr_axi_slave_mem_pkg.sv
// Shared constants and types for the DDR AXI slave memory responder.
package ddr_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask on bits [15],[13],[12],[10]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ddr_axi_slave_mem_if.sv
// AXI4 bus bundle between the DDR_interface M00_AXI master and the slave memory.
interface ddr_axi_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     S_AXI_AWID;
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]              S_AXI_AWLEN;
  logic [1:0]              S_AXI_AWBURST;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [ID_WIDTH-1:0]     S_AXI_BID;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ID_WIDTH-1:0]     S_AXI_ARID;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]              S_AXI_ARLEN;
  logic [1:0]              S_AXI_ARBURST;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [ID_WIDTH-1:0]     S_AXI_RID;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/ddr_axi_slave_mem_stall_lfsr.sv
// Pseudo-random backpressure source: 16-bit Fibonacci LFSR, stall = bit 0.
module ddr_axi_stall_lfsr
  import ddr_axi_pkg::*;
(
  input  logic ACLK,
  input  logic ARESETN,
  output logic stall
);
  logic [15:0] lfsr;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall = lfsr[0];
endmodule

// File: rtl/ddr_axi_slave_mem.sv
// AXI4 slave scratch memory, one burst at a time, full-width beats.
// Define DDR_SLV_STALL_EN to add LFSR-driven WREADY/RVALID backpressure.
module ddr_axi_slave_mem
  import ddr_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_DEPTH  = 1024
)(
  input logic                ACLK,
  input logic                ARESETN,
  ddr_axi_slave_mem_if.slave s_axi
);
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_W);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state, state_nxt;
  logic                  wr_prio;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q, cnt_q;
  logic [1:0]            burst_q;
  logic                  slv_err_q, dec_err_q;
  logic                  rvalid_hold;
  logic                  stall;

  logic awready, arready, wready, bvalid, rvalid;
  logic aw_grant, ar_grant, w_hs, r_hs;
  logic in_range, last_beat;
  logic [IDX_W-1:0] idx;
  logic unused_lsb;

`ifdef DDR_SLV_STALL_EN
  ddr_axi_stall_lfsr u_stall (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .stall   (stall)
  );
`else
  assign stall = 1'b0;
`endif

  assign idx        = addr_q[ADDR_LSB +: IDX_W];
  assign in_range   = (addr_q[ADDR_WIDTH-1:ADDR_LSB+IDX_W] == '0);
  assign last_beat  = (cnt_q == len_q);
  assign unused_lsb = &{1'b0, addr_q[ADDR_LSB-1:0]};

  // Pointer only matters on a tie; a lone request always wins
  assign aw_grant = s_axi.S_AXI_AWVALID && (!s_axi.S_AXI_ARVALID || wr_prio);
  assign ar_grant = s_axi.S_AXI_ARVALID && !aw_grant;

  assign w_hs = wready && s_axi.S_AXI_WVALID;
  assign r_hs = rvalid && s_axi.S_AXI_RREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    case (state)
      IDLE: begin
        awready = ARESETN && aw_grant;
        arready = ARESETN && ar_grant;
        if (awready)      state_nxt = WDATA;
        else if (arready) state_nxt = RDATA;
      end
      WDATA: begin
        wready = !stall;
        if (wready && s_axi.S_AXI_WVALID && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        bvalid = 1'b1;
        if (s_axi.S_AXI_BREADY) state_nxt = IDLE;
      end
      RDATA: begin
        // Once presented, a beat stays valid regardless of the stall source
        rvalid = !stall || rvalid_hold;
        if (rvalid && s_axi.S_AXI_RREADY && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_prio     <= 1'b1;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      slv_err_q   <= 1'b0;
      dec_err_q   <= 1'b0;
      rvalid_hold <= 1'b0;
    end else begin
      if (awready || arready) begin
        if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_ARVALID) wr_prio <= !wr_prio;
        id_q      <= awready ? s_axi.S_AXI_AWID    : s_axi.S_AXI_ARID;
        addr_q    <= awready ? s_axi.S_AXI_AWADDR  : s_axi.S_AXI_ARADDR;
        len_q     <= awready ? s_axi.S_AXI_AWLEN   : s_axi.S_AXI_ARLEN;
        burst_q   <= awready ? s_axi.S_AXI_AWBURST : s_axi.S_AXI_ARBURST;
        slv_err_q <= awready && s_axi.S_AXI_AWBURST[1];
        dec_err_q <= 1'b0;
        cnt_q     <= '0;
      end
      if (w_hs || r_hs) begin
        cnt_q <= cnt_q + 8'd1;
        if (burst_q != BURST_FIXED) addr_q <= addr_q + BEAT_BYTES;
      end
      if (w_hs) begin
        if (!in_range) dec_err_q <= 1'b1;
        if (s_axi.S_AXI_WLAST != last_beat) slv_err_q <= 1'b1;
      end
      rvalid_hold <= rvalid && !s_axi.S_AXI_RREADY;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && in_range) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) mem[idx][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BID     = id_q;
  assign s_axi.S_AXI_BRESP   = !bvalid  ? RESP_OKAY   :
                               dec_err_q ? RESP_DECERR :
                               slv_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RID     = id_q;
  assign s_axi.S_AXI_RLAST   = rvalid && last_beat;
  assign s_axi.S_AXI_RDATA   = (rvalid && in_range) ? mem[idx] : '0;
  assign s_axi.S_AXI_RRESP   = !rvalid    ? RESP_OKAY   :
                               !in_range  ? RESP_DECERR :
                               burst_q[1] ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_ddr_axi_slave_mem.sv
// Directed self-checking bench for ddr_axi_slave_mem.
module tb_ddr_axi_slave_mem;
  import ddr_axi_pkg::*;

  localparam int DW = 32, AW = 32, IW = 1, DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   hs_ok;

  logic [DW-1:0] wr_data [16];
  logic [3:0]    wr_strb [16];
  logic [DW-1:0] rd_data [16];
  logic [1:0]    rd_resp [16];
  logic          rd_last [16];
  logic [IW-1:0] rd_id   [16];
  logic [1:0]    bresp;
  logic [IW-1:0] bid;
  int            lat;

  always #5 clk = ~clk;

  ddr_axi_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  ddr_axi_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .s_axi   (bus)
  );

  task automatic idle_inputs();
    bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWBURST = BURST_INCR;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARBURST = BURST_INCR;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic aw_req(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                        input logic [7:0] len, input logic [1:0] burst);
    int k = 0;
    bus.S_AXI_AWID = id; bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = len;
    bus.S_AXI_AWBURST = burst; bus.S_AXI_AWVALID = 1'b1;
    #1;
    while (bus.S_AXI_AWREADY !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) hs_ok = 1'b0;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic ar_req(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                        input logic [7:0] len, input logic [1:0] burst);
    int k = 0;
    bus.S_AXI_ARID = id; bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = len;
    bus.S_AXI_ARBURST = burst; bus.S_AXI_ARVALID = 1'b1;
    #1;
    while (bus.S_AXI_ARREADY !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) hs_ok = 1'b0;
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic w_beats(input int n, input int wlast_at);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      bus.S_AXI_WDATA = wr_data[i]; bus.S_AXI_WSTRB = wr_strb[i];
      bus.S_AXI_WLAST = (i == wlast_at); bus.S_AXI_WVALID = 1'b1;
      #1;
      while (bus.S_AXI_WREADY !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      if (k >= 50) hs_ok = 1'b0;
      @(posedge clk); #1;
    end
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
  endtask

  task automatic b_wait();
    bus.S_AXI_BREADY = 1'b1;
    #1;
    lat = 0;
    while (bus.S_AXI_BVALID !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (lat >= 50) hs_ok = 1'b0;
    bresp = bus.S_AXI_BRESP; bid = bus.S_AXI_BID;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic r_beats(input int n);
    bus.S_AXI_RREADY = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (bus.S_AXI_RVALID !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      if (k >= 50) hs_ok = 1'b0;
      if (i == 0) lat = k;
      rd_data[i] = bus.S_AXI_RDATA; rd_resp[i] = bus.S_AXI_RRESP;
      rd_last[i] = bus.S_AXI_RLAST; rd_id[i] = bus.S_AXI_RID;
      @(posedge clk); #1;
    end
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW+IW*2+11:0] outs;
    idle_inputs();
    rst_n = 1'b0;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
            bus.S_AXI_BRESP, bus.S_AXI_BID, bus.S_AXI_RVALID, bus.S_AXI_RDATA,
            bus.S_AXI_RRESP, bus.S_AXI_RLAST, bus.S_AXI_RID};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_incr_burst();
    hs_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h11 * (i + 1); wr_strb[i] = 4'hF; end
    aw_req(0, 32'h10, 8'd3, BURST_INCR);
`ifndef DDR_SLV_STALL_EN
    n_cmp++; if (bus.S_AXI_WREADY !== 1'b1) begin n_bad++; $display("FAIL aw_to_wready: got %b want 1", bus.S_AXI_WREADY); end
`endif
    w_beats(4, 3);
    b_wait();
`ifndef DDR_SLV_STALL_EN
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL wlast_to_bvalid: got %0d cycles want 0 extra", lat); end
`endif
    n_cmp++; if (bresp !== RESP_OKAY) begin n_bad++; $display("FAIL incr_bresp: got %b want %b", bresp, RESP_OKAY); end
    ar_req(0, 32'h10, 8'd3, BURST_INCR);
    r_beats(4);
`ifndef DDR_SLV_STALL_EN
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL ar_to_rvalid: got %0d cycles want 0 extra", lat); end
`endif
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_data[i] !== 32'h11 * (i + 1)) begin n_bad++; $display("FAIL incr_rdata[%0d]: got %h want %h", i, rd_data[i], 32'h11 * (i + 1)); end
      n_cmp++; if (rd_resp[i] !== RESP_OKAY) begin n_bad++; $display("FAIL incr_rresp[%0d]: got %b want 00", i, rd_resp[i]); end
      n_cmp++; if (rd_last[i] !== (i == 3)) begin n_bad++; $display("FAIL incr_rlast[%0d]: got %b want %b", i, rd_last[i], (i == 3)); end
    end
    n_cmp++; if (hs_ok !== 1'b1) begin n_bad++; $display("FAIL incr_handshake_timeout: got %b want 1", hs_ok); end
  endtask

  task automatic test_strobe();
    hs_ok = 1'b1;
    wr_data[0] = 32'h0; wr_strb[0] = 4'hF;
    aw_req(0, 32'h20, 8'd0, BURST_INCR); w_beats(1, 0); b_wait();
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'b0101;
    aw_req(0, 32'h20, 8'd0, BURST_INCR); w_beats(1, 0); b_wait();
    n_cmp++; if (bresp !== RESP_OKAY) begin n_bad++; $display("FAIL strobe_bresp: got %b want 00", bresp); end
    ar_req(0, 32'h20, 8'd0, BURST_INCR); r_beats(1);
    n_cmp++; if (rd_data[0] !== 32'h00AD00EF) begin n_bad++; $display("FAIL strobe_rdata: got %h want 00ad00ef", rd_data[0]); end
    n_cmp++; if (rd_last[0] !== 1'b1) begin n_bad++; $display("FAIL strobe_rlast: got %b want 1", rd_last[0]); end
    n_cmp++; if (hs_ok !== 1'b1) begin n_bad++; $display("FAIL strobe_handshake_timeout: got %b want 1", hs_ok); end
  endtask

  task automatic test_arbitration();
    hs_ok = 1'b1;
    bus.S_AXI_AWID = 1'b1; bus.S_AXI_AWADDR = 32'h40; bus.S_AXI_AWLEN = 8'd0; bus.S_AXI_AWBURST = BURST_INCR;
    bus.S_AXI_ARID = 1'b0; bus.S_AXI_ARADDR = 32'h40; bus.S_AXI_ARLEN = 8'd0; bus.S_AXI_ARBURST = BURST_INCR;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    #1;
    n_cmp++; if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 2'b10) begin n_bad++; $display("FAIL tie1_grant: got aw/ar=%b want 10", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}); end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    wr_data[0] = 32'hCAFE0001; wr_strb[0] = 4'hF;
    w_beats(1, 0); b_wait();
    n_cmp++; if (bid !== 1'b1) begin n_bad++; $display("FAIL tie_bid: got %b want 1", bid); end
    n_cmp++; if (bresp !== RESP_OKAY) begin n_bad++; $display("FAIL tie_bresp: got %b want 00", bresp); end
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    #1;
    n_cmp++; if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 2'b01) begin n_bad++; $display("FAIL tie2_grant: got aw/ar=%b want 01", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}); end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    r_beats(1);
    n_cmp++; if (rd_id[0] !== 1'b0) begin n_bad++; $display("FAIL tie_rid: got %b want 0", rd_id[0]); end
    n_cmp++; if (rd_data[0] !== 32'hCAFE0001) begin n_bad++; $display("FAIL tie_rdata: got %h want cafe0001", rd_data[0]); end
    n_cmp++; if (hs_ok !== 1'b1) begin n_bad++; $display("FAIL tie_handshake_timeout: got %b want 1", hs_ok); end
  endtask

  task automatic test_out_of_range();
    hs_ok = 1'b1;
    wr_data[0] = 32'h5A5A0001; wr_data[1] = 32'h5A5A0002; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    aw_req(0, 32'hFFC, 8'd1, BURST_INCR); w_beats(2, 1); b_wait();
    n_cmp++; if (bresp !== RESP_DECERR) begin n_bad++; $display("FAIL oor_bresp: got %b want 11", bresp); end
    // Out-of-range outranks the WRAP slave error
    aw_req(0, 32'hFFC, 8'd1, BURST_WRAP); w_beats(2, 1); b_wait();
    n_cmp++; if (bresp !== RESP_DECERR) begin n_bad++; $display("FAIL oor_wrap_bresp: got %b want 11", bresp); end
    ar_req(0, 32'hFFC, 8'd1, BURST_INCR); r_beats(2);
    n_cmp++; if (rd_resp[0] !== RESP_OKAY) begin n_bad++; $display("FAIL oor_rresp0: got %b want 00", rd_resp[0]); end
    n_cmp++; if (rd_data[0] !== 32'h5A5A0001) begin n_bad++; $display("FAIL oor_rdata0: got %h want 5a5a0001", rd_data[0]); end
    n_cmp++; if (rd_resp[1] !== RESP_DECERR) begin n_bad++; $display("FAIL oor_rresp1: got %b want 11", rd_resp[1]); end
    n_cmp++; if (rd_data[1] !== 32'h0) begin n_bad++; $display("FAIL oor_rdata1: got %h want 0", rd_data[1]); end
    n_cmp++; if (rd_last[1] !== 1'b1) begin n_bad++; $display("FAIL oor_rlast1: got %b want 1", rd_last[1]); end
    n_cmp++; if (hs_ok !== 1'b1) begin n_bad++; $display("FAIL oor_handshake_timeout: got %b want 1", hs_ok); end
  endtask

  task automatic test_wlast_fixed_wrap();
    hs_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA1 + i; wr_strb[i] = 4'hF; end
    aw_req(0, 32'h80, 8'd2, BURST_INCR); w_beats(3, 1); b_wait();
    n_cmp++; if (bresp !== RESP_SLVERR) begin n_bad++; $display("FAIL early_wlast_bresp: got %b want 10", bresp); end
    ar_req(0, 32'h80, 8'd2, BURST_INCR); r_beats(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rd_data[i] !== 32'hA1 + i) begin n_bad++; $display("FAIL early_wlast_rdata[%0d]: got %h want %h", i, rd_data[i], 32'hA1 + i); end
    end
    aw_req(0, 32'h88, 8'd0, BURST_INCR); w_beats(1, -1); b_wait();
    n_cmp++; if (bresp !== RESP_SLVERR) begin n_bad++; $display("FAIL missing_wlast_bresp: got %b want 10", bresp); end
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hB1 + i;
    aw_req(0, 32'h90, 8'd3, BURST_FIXED); w_beats(4, 3); b_wait();
    n_cmp++; if (bresp !== RESP_OKAY) begin n_bad++; $display("FAIL fixed_bresp: got %b want 00", bresp); end
    ar_req(0, 32'h90, 8'd0, BURST_INCR); r_beats(1);
    n_cmp++; if (rd_data[0] !== 32'hB4) begin n_bad++; $display("FAIL fixed_rdata: got %h want 000000b4", rd_data[0]); end
    wr_data[0] = 32'hC1; wr_data[1] = 32'hC2;
    aw_req(0, 32'hA0, 8'd1, BURST_WRAP); w_beats(2, 1); b_wait();
    n_cmp++; if (bresp !== RESP_SLVERR) begin n_bad++; $display("FAIL wrap_bresp: got %b want 10", bresp); end
    ar_req(0, 32'hA0, 8'd1, BURST_WRAP); r_beats(2);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rd_data[i] !== 32'hC1 + i) begin n_bad++; $display("FAIL wrap_rdata[%0d]: got %h want %h", i, rd_data[i], 32'hC1 + i); end
      n_cmp++; if (rd_resp[i] !== RESP_SLVERR) begin n_bad++; $display("FAIL wrap_rresp[%0d]: got %b want 10", i, rd_resp[i]); end
    end
    n_cmp++; if (hs_ok !== 1'b1) begin n_bad++; $display("FAIL wlast_handshake_timeout: got %b want 1", hs_ok); end
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] held;
    logic [DW+IW*2+11:0] outs;
    int k = 0;
    hs_ok = 1'b1;
    ar_req(0, 32'h10, 8'd7, BURST_INCR);
    r_beats(1);
    while (bus.S_AXI_RVALID !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) hs_ok = 1'b0;
    held = bus.S_AXI_RDATA;
    @(posedge clk); #1;
    n_cmp++; if ({bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_RDATA} !== {2'b10, 32'h22}) begin n_bad++; $display("FAIL rdata_hold: got v/l/d=%b%b %h want 10 00000022", bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_RDATA); end
    n_cmp++; if (held !== 32'h22) begin n_bad++; $display("FAIL beat2_rdata: got %h want 00000022", held); end
    rst_n = 1'b0;
    #1;
    outs = {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
            bus.S_AXI_BRESP, bus.S_AXI_BID, bus.S_AXI_RVALID, bus.S_AXI_RDATA,
            bus.S_AXI_RRESP, bus.S_AXI_RLAST, bus.S_AXI_RID};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL mid_read_reset_outputs: got %h want 0", outs); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ar_req(0, 32'h10, 8'd0, BURST_INCR); r_beats(1);
    n_cmp++; if ({rd_resp[0], rd_last[0], rd_data[0]} !== {RESP_OKAY, 1'b1, 32'h11}) begin n_bad++; $display("FAIL post_reset_read: got r/l/d=%b %b %h want 00 1 00000011", rd_resp[0], rd_last[0], rd_data[0]); end
    wr_data[0] = 32'hD1; wr_data[1] = 32'hD2; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    aw_req(0, 32'h300, 8'd3, BURST_INCR); w_beats(2, -1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 2'b00) begin n_bad++; $display("FAIL mid_write_reset: got wready/bvalid=%b want 00", {bus.S_AXI_WREADY, bus.S_AXI_BVALID}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ar_req(0, 32'h300, 8'd1, BURST_INCR); r_beats(2);
    n_cmp++; if ({rd_data[0], rd_data[1]} !== {32'hD1, 32'hD2}) begin n_bad++; $display("FAIL aborted_write_bytes: got %h %h want 000000d1 000000d2", rd_data[0], rd_data[1]); end
    n_cmp++; if (hs_ok !== 1'b1) begin n_bad++; $display("FAIL reset_handshake_timeout: got %b want 1", hs_ok); end
  endtask

  initial begin
    test_reset();
    test_incr_burst();
    test_strobe();
    test_arbitration();
    test_out_of_range();
    test_wlast_fixed_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end
endmodule
